mem_rd_engine: RTL and testbench

Bulk-read engine that sits directly between the accelerator's memory front end and the CCI-P channel 0 request/response path. Given a line-aligned base address and a line count, it issues 64-byte read requests, keeps up to 8 in flight, reorders out-of-order responses, and presents lines strictly in address order on a valid/ready stream. The front end uses one engine per load phase: image, program, RNN weights or DNN weights.

---
 rtl/mem_rd_engine.sv | 216 +++++++++++++++++++++
 tb/tb_mem_rd_engine.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rd_engine.sv
// mem_rd_engine: bulk cache-line read engine for the CCI-P channel 0 path.
// Issues 64-byte RDLINE_I reads starting at a line-aligned base address.
// Keeps up to MAX_OUTSTANDING requests in flight. Out-of-order responses
// are parked in a reorder buffer (ROB) indexed by the request tag, and lines
// are released on a valid/ready stream strictly in address order.
//
// Optional feature: define MEM_RD_PERF_EN to build the almost-full stall
// counter on perf_stall_cnt. When the macro is undefined the port is tied to
// zero and no counter logic exists.
module mem_rd_engine #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [41:0]       base_addr,
    input  logic [CNT_W-1:0]  line_count,
    output logic              busy,
    output logic              done,
    output logic              c0_req_valid,
    output logic [41:0]       c0_req_addr,
    output logic [15:0]       c0_req_mdata,
    input  logic              c0_almfull,
    input  logic              c0_rsp_valid,
    input  logic [15:0]       c0_rsp_mdata,
    input  logic [511:0]      c0_rsp_data,
    output logic              line_valid,
    output logic [511:0]      line_data,
    input  logic              line_ready,
    output logic              err,
    output logic [31:0]       perf_stall_cnt
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam logic [PW-1:0]    PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t                     state;

    // Transfer descriptor captured at start
    logic [41:0]                base_q;
    logic [CNT_W-1:0]           count_q;

    // Progress counters and ROB pointers
    logic [CNT_W-1:0]           issue_cnt;
    logic [CNT_W-1:0]           retire_cnt;
    logic [PW-1:0]              issue_ptr;
    logic [PW-1:0]              retire_ptr;

    // Per-slot bookkeeping: pending = request issued and slot not yet
    // retired, full = response data has landed in the slot
    logic [MAX_OUTSTANDING-1:0] pending;
    logic [MAX_OUTSTANDING-1:0] full;
    logic [511:0]               rob_mem [MAX_OUTSTANDING];

    // Output register
    logic                       out_valid;
    logic [511:0]               out_data;

    // Per-cycle decisions
    logic                       engine_active;
    logic                       issue_go;
    logic                       retire_go;
    logic                       out_fire;
    logic [PW-1:0]              rsp_idx;
    logic                       rsp_accept;
    logic                       rsp_stray;

    // Only the slot-index bits of the returned tag are meaningful
    logic                       unused_rsp_mdata_hi;
    assign unused_rsp_mdata_hi = ^c0_rsp_mdata[15:PW];

    // Decode this cycle's issue, retire and response actions from the registered state
    always_comb begin
        engine_active = (state == ISSUE) || (state == DRAIN);
        issue_go      = (state == ISSUE) && (issue_cnt < count_q) &&
                        !c0_almfull && !pending[issue_ptr];
        out_fire      = out_valid && line_ready;
        retire_go     = engine_active && full[retire_ptr] &&
                        (!out_valid || line_ready);
        rsp_idx       = c0_rsp_mdata[PW-1:0];
        rsp_accept    = c0_rsp_valid && engine_active && pending[rsp_idx];
        rsp_stray     = c0_rsp_valid && engine_active && !pending[rsp_idx];
    end

    // The request is presented in the same cycle almost-full is sampled so
    // that no request ever coincides with c0_almfull=1
    assign c0_req_valid = issue_go;
    assign c0_req_addr  = base_q + 42'(issue_cnt);
    assign c0_req_mdata = 16'(issue_ptr);
    assign line_valid   = out_valid;
    assign line_data    = out_data;

    // ROB data store: response lines land in the slot named by their tag
    always_ff @(posedge clk) begin
        if (rsp_accept) begin
            rob_mem[rsp_idx] <= c0_rsp_data;
        end
    end

    // Main control: state machine, slot bookkeeping, output register and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            base_q     <= '0;
            count_q    <= '0;
            issue_cnt  <= '0;
            retire_cnt <= '0;
            issue_ptr  <= '0;
            retire_ptr <= '0;
            pending    <= '0;
            full       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;

            if (rsp_stray) begin
                err <= 1'b1;
            end

            if (rsp_accept) begin
                full[rsp_idx] <= 1'b1;
            end

            if (issue_go) begin
                pending[issue_ptr] <= 1'b1;
                issue_ptr          <= issue_ptr + PTR_ONE;
                issue_cnt          <= issue_cnt + CNT_ONE;
            end

            if (retire_go) begin
                pending[retire_ptr] <= 1'b0;
                full[retire_ptr]    <= 1'b0;
                retire_ptr          <= retire_ptr + PTR_ONE;
                retire_cnt          <= retire_cnt + CNT_ONE;
                out_valid           <= 1'b1;
                out_data            <= rob_mem[retire_ptr];
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        base_q     <= base_addr;
                        count_q    <= line_count;
                        issue_cnt  <= '0;
                        retire_cnt <= '0;
                        issue_ptr  <= '0;
                        retire_ptr <= '0;
                        pending    <= '0;
                        full       <= '0;
                        busy       <= 1'b1;
                        if (line_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue_go && ((issue_cnt + CNT_ONE) == count_q)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_fire && (retire_cnt == count_q)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_RD_PERF_EN
    logic [31:0] perf_q;

    // Count ISSUE cycles where a request is wanted but almost-full holds it back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if ((state == IDLE) && start) begin
            perf_q <= '0;
        end else if ((state == ISSUE) && (issue_cnt < count_q) &&
                     c0_almfull && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_rd_engine.sv
// tb_mem_rd_engine: randomized self-checking bench for mem_rd_engine.
// A behavioural memory answers requests (in order, shuffled or scripted),
// and the reference model expects requests and output lines to walk the
// address range base..base+count-1 in order, with line data derived from
// the address. Honours MEM_RD_PERF_EN for the stall counter expectation.
module tb_mem_rd_engine;

    localparam int N = 8;

`ifdef MEM_RD_PERF_EN
    localparam int EXP_STALLS = 10;
`else
    localparam int EXP_STALLS = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [41:0]  base_addr;
    logic [15:0]  line_count;
    logic         busy;
    logic         done;
    logic         c0_req_valid;
    logic [41:0]  c0_req_addr;
    logic [15:0]  c0_req_mdata;
    logic         c0_almfull;
    logic         c0_rsp_valid;
    logic [15:0]  c0_rsp_mdata;
    logic [511:0] c0_rsp_data;
    logic         line_valid;
    logic [511:0] line_data;
    logic         line_ready;
    logic         err;
    logic [31:0]  perf_stall_cnt;

    always #5 clk = ~clk;

    mem_rd_engine #(.MAX_OUTSTANDING(N), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .line_count(line_count), .busy(busy), .done(done),
        .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr),
        .c0_req_mdata(c0_req_mdata), .c0_almfull(c0_almfull),
        .c0_rsp_valid(c0_rsp_valid), .c0_rsp_mdata(c0_rsp_mdata),
        .c0_rsp_data(c0_rsp_data), .line_valid(line_valid),
        .line_data(line_data), .line_ready(line_ready), .err(err),
        .perf_stall_cnt(perf_stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Bench knobs and model state
    int          cyc, start_cyc;
    int          af_lo, af_hi, ready_low_until, ready_pct, rsp_pct;
    bit          rsp_random_pick;
    int          stray_cyc;
    logic [15:0] stray_tag;
    bit          start_pending;
    logic [41:0] start_base;
    logic [15:0] start_cnt;
    logic [41:0] exp_req_addr, exp_out_addr;
    int          req_seen, lines_seen, xfer_count, prev_tag;
    int          first_req_cyc, first_rsp_cyc, first_line_cyc;
    int          last_accept_cyc, done_cyc, bp_snap;
    bit          hold_valid;
    logic [511:0] hold_data;
    bit          exp_err;
    logic [15:0] oq_tag[$];
    logic [41:0] oq_addr[$];
    logic [15:0] script[$];

    task automatic checkOutput(input string tag, input logic [511:0] got,
                               input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory contents: every line is a pattern built from its own address
    function automatic logic [511:0] lineOf(input logic [41:0] a);
        logic [511:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) begin
            v[k*64 +: 64] = {k[21:0], a};
        end
        return v;
    endfunction

    // One clock cycle: drive inputs after the edge, then observe and check
    task automatic applyStimulus();
        int pick;
        int rel;
        pick = -1;
        @(posedge clk);
        #1;
        cyc++;
        start        = 1'b0;
        c0_rsp_valid = 1'b0;
        c0_rsp_mdata = '0;
        c0_rsp_data  = '0;
        if (start_pending) begin
            start         = 1'b1;
            base_addr     = start_base;
            line_count    = start_cnt;
            start_pending = 1'b0;
            start_cyc     = cyc;
        end
        rel        = cyc - start_cyc;
        c0_almfull = (rel >= af_lo) && (rel <= af_hi);
        line_ready = (rel < ready_low_until) ? 1'b0
                                             : ($urandom_range(0, 99) < ready_pct);

        if (stray_cyc >= 0 && rel == stray_cyc) begin
            c0_rsp_valid = 1'b1;
            c0_rsp_mdata = stray_tag;
            c0_rsp_data  = lineOf(42'h3FF_FFFF);
            stray_cyc    = -1;
        end else if (script.size() != 0) begin
            for (int i = 0; i < oq_tag.size(); i++) begin
                if (oq_tag[i] == script[0]) pick = i;
            end
            if (pick >= 0) void'(script.pop_front());
        end else if (oq_tag.size() != 0 && $urandom_range(0, 99) < rsp_pct) begin
            pick = rsp_random_pick ? int'($urandom_range(0, oq_tag.size() - 1)) : 0;
        end
        if (pick >= 0) begin
            c0_rsp_valid = 1'b1;
            c0_rsp_mdata = oq_tag[pick];
            c0_rsp_data  = lineOf(oq_addr[pick]);
            if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
            oq_tag.delete(pick);
            oq_addr.delete(pick);
        end

        #1;
        if (hold_valid) begin
            checkOutput("hold_valid", line_valid, 1'b1);
            checkOutput("hold_data", line_data, hold_data);
        end
        hold_valid = line_valid && !line_ready;
        hold_data  = line_data;

        if (c0_req_valid) begin
            checkOutput("req_almfull", c0_almfull, 1'b0);
            checkOutput("req_addr", c0_req_addr, exp_req_addr);
            if (prev_tag >= 0)
                checkOutput("req_tag", c0_req_mdata, 16'((prev_tag + 1) % N));
            else
                checkOutput("req_tag_hi", c0_req_mdata[15:3], 13'd0);
            prev_tag = int'(c0_req_mdata);
            if (first_req_cyc < 0) first_req_cyc = cyc;
            oq_tag.push_back(c0_req_mdata);
            oq_addr.push_back(c0_req_addr);
            exp_req_addr++;
            req_seen++;
            checkOutput("req_in_range", req_seen <= xfer_count, 1'b1);
            // Eight ROB slots plus the output register bound the lines in flight
            checkOutput("inflight", (req_seen - lines_seen) <= N + 1, 1'b1);
        end

        if (line_valid && first_line_cyc < 0) first_line_cyc = cyc;
        if (line_valid && line_ready) begin
            checkOutput("line_data", line_data, lineOf(exp_out_addr));
            exp_out_addr++;
            lines_seen++;
            last_accept_cyc = cyc;
        end
        if (ready_low_until > 0 && rel == ready_low_until - 1) bp_snap = req_seen;
        if (done && done_cyc < 0) done_cyc = cyc;
    endtask

    // Start a transfer and follow it until done (bounded), then check the wrap-up
    task automatic runTransfer(input logic [41:0] b, input int cnt, input int budget);
        start_base      = b;
        start_cnt       = cnt[15:0];
        start_pending   = 1'b1;
        exp_req_addr    = b;
        exp_out_addr    = b;
        xfer_count      = cnt;
        req_seen        = 0;
        lines_seen      = 0;
        prev_tag        = -1;
        first_req_cyc   = -1;
        first_rsp_cyc   = -1;
        first_line_cyc  = -1;
        last_accept_cyc = -1;
        done_cyc        = -1;
        applyStimulus();
        applyStimulus();
        checkOutput("busy_after_start", busy, 1'b1);
        for (int i = 0; i < budget && done_cyc < 0; i++) applyStimulus();
        checkOutput("done_seen", done_cyc >= 0, 1'b1);
        checkOutput("lines_delivered", lines_seen, cnt);
        checkOutput("reqs_issued", req_seen, cnt);
        if (cnt > 0) checkOutput("done_latency", done_cyc - last_accept_cyc, 1);
        checkOutput("err", err, exp_err);
        applyStimulus();
        checkOutput("busy_idle", busy, 1'b0);
        checkOutput("done_pulse", done, 1'b0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkOutput({tag, "_done"}, done, 1'b0);
        checkOutput({tag, "_req_valid"}, c0_req_valid, 1'b0);
        checkOutput({tag, "_req_addr"}, c0_req_addr, 42'd0);
        checkOutput({tag, "_req_mdata"}, c0_req_mdata, 16'd0);
        checkOutput({tag, "_line_valid"}, line_valid, 1'b0);
        checkOutput({tag, "_line_data"}, line_data, 512'd0);
        checkOutput({tag, "_err"}, err, 1'b0);
        checkOutput({tag, "_perf"}, perf_stall_cnt, 32'd0);
    endtask

    task automatic setDefaults();
        af_lo = 1; af_hi = 0;
        ready_low_until = 0; ready_pct = 100;
        rsp_pct = 100; rsp_random_pick = 1'b0;
        stray_cyc = -1; stray_tag = '0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; line_count = '0;
        c0_almfull = 1'b0; c0_rsp_valid = 1'b0; c0_rsp_mdata = '0;
        c0_rsp_data = '0; line_ready = 1'b0;
        cyc = 0; start_cyc = 0; start_pending = 1'b0; hold_valid = 1'b0;
        hold_data = '0; exp_err = 1'b0; bp_snap = 0; xfer_count = 0;
        req_seen = 0; lines_seen = 0; prev_tag = -1;
        exp_req_addr = '0; exp_out_addr = '0; start_base = '0; start_cnt = '0;
        first_req_cyc = -1; first_rsp_cyc = -1; first_line_cyc = -1;
        last_accept_cyc = -1; done_cyc = -1;
        setDefaults();
        repeat (3) @(posedge clk);
        #2;
        checkResetOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic in-order read with fixed latencies
        $display("[TB] basic in-order read");
        runTransfer(42'h100, 4, 100);
        checkOutput("first_req_latency", first_req_cyc - start_cyc, 1);
        checkOutput("rsp_to_line_latency", first_line_cyc - first_rsp_cyc, 2);

        // Scripted out-of-order responses
        $display("[TB] out-of-order responses");
        script = '{16'd7, 16'd3, 16'd0, 16'd1, 16'd2, 16'd6, 16'd5, 16'd4};
        runTransfer(42'h2_0000, 8, 200);

        // Downstream backpressure fills the ROB, then releases
        $display("[TB] backpressure");
        setDefaults();
        ready_low_until = 30; rsp_random_pick = 1'b1;
        runTransfer(42'h4_0000, 20, 400);
        checkOutput("bp_rob_filled", (bp_snap >= N) && (bp_snap <= N + 1), 1'b1);

        // Almost-full window blocks requests
        $display("[TB] almost-full window");
        setDefaults();
        af_lo = 3; af_hi = 12; rsp_random_pick = 1'b1; ready_pct = 80;
        runTransfer(42'h8_0000, 16, 400);
        checkOutput("perf_stall_cnt", perf_stall_cnt, 32'(EXP_STALLS));

        // Zero-length transfer
        $display("[TB] zero count");
        setDefaults();
        runTransfer(42'h123, 0, 20);
        checkOutput("zero_done_window",
                    (done_cyc - start_cyc >= 1) && (done_cyc - start_cyc <= 2), 1'b1);

        // Randomized transfers, including one that wraps the 42-bit address
        $display("[TB] randomized transfers");
        for (int t = 0; t < 5; t++) begin
            logic [41:0] b;
            int          c;
            setDefaults();
            rsp_random_pick = 1'b1;
            rsp_pct   = int'($urandom_range(40, 100));
            ready_pct = int'($urandom_range(30, 100));
            b = {$urandom(), $urandom()};
            c = int'($urandom_range(1, 40));
            if (t == 0) begin
                b = 42'h3FF_FFFF_FFFD;
                c = 6;
            end
            runTransfer(b, c, 2000);
        end

        // Stray response to a free slot while issuing
        $display("[TB] stray response");
        setDefaults();
        af_lo = 0; af_hi = 3; stray_cyc = 2; stray_tag = 16'd5;
        exp_err = 1'b1;
        runTransfer(42'h500, 2, 100);

        // Reset in the middle of a transfer
        $display("[TB] reset mid-transfer");
        setDefaults();
        start_base = 42'h900; start_cnt = 16'd8; start_pending = 1'b1;
        exp_req_addr = 42'h900; exp_out_addr = 42'h900; xfer_count = 8;
        req_seen = 0; lines_seen = 0; prev_tag = -1; done_cyc = -1;
        for (int i = 0; i < 100 && lines_seen < 3; i++) applyStimulus();
        checkOutput("mid_lines_reached", lines_seen >= 3, 1'b1);
        applyStimulus();
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midreset");
        oq_tag.delete(); oq_addr.delete(); script.delete();
        hold_valid = 1'b0; exp_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        runTransfer(42'hA00, 2, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
